dpb_mem_ctrl: RTL and testbench

DPB_MEM_CTRL -- requirements
Module: dpb_mem_ctrl

---
 rtl/dpb_mem_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_dpb_mem_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpb_mem_ctrl.sv
// Splits 32-bit core word accesses into two 16-bit dual-port block RAM accesses (low half, then high half).
// Latency: write response 3 cycles, read response 5 cycles after acceptance; misaligned reject 1 cycle (DPB_MEM_CTRL_ALIGN_CHK_EN).
// Backpressure: req_ready only in IDLE, one request outstanding; rsp_valid is a single-cycle pulse that cannot be stalled.
module dpb_mem_ctrl #(
    parameter logic [2:0] BLKSEL = 3'b000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [12:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_wstrb,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        ram_reset,
    output logic        ram_ce,
    output logic        ram_oce,
    output logic        ram_wre,
    output logic [13:0] ram_ad,
    output logic [15:0] ram_din,
    input  logic [15:0] ram_dout,
    output logic [2:0]  ram_blksel
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE_LO = 3'd1,
        ISSUE_HI = 3'd2,
        READ_LO  = 3'd3,
        READ_HI  = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        accept;
    logic        misalign;

    logic        we_q;
    logic [10:0] word_q;
    logic [15:0] wdata_hi_q;
    logic        wstrb_hi_q;
    logic [15:0] low_q;

    logic        ce_d;
    logic        wre_d;
    logic        oce_d;
    logic [13:0] ad_d;
    logic [15:0] din_d;
    logic        rsp_vld_d;
    logic [31:0] rdata_d;
    logic        err_d;

    assign ram_reset  = reset;
    assign ram_blksel = BLKSEL;
    assign req_ready  = (state == IDLE) && !reset;
    assign accept     = req_valid && req_ready;

`ifdef DPB_MEM_CTRL_ALIGN_CHK_EN
    assign misalign = (req_addr[1:0] != 2'b00);
`else
    logic [2:0] unused_bits;
    assign misalign    = 1'b0;
    assign unused_bits = {req_addr[1:0], err_d};
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (accept && !misalign) state_nxt = ISSUE_LO;
            ISSUE_LO: state_nxt = ISSUE_HI;
            ISSUE_HI: state_nxt = we_q ? IDLE : READ_LO;
            READ_LO:  state_nxt = READ_HI;
            READ_HI:  state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Outputs are computed one state ahead and registered, so the RAM pins are glitch-free
    // and ram_ad/ram_din naturally hold their last value while idle.
    always_comb begin
        ce_d      = 1'b0;
        wre_d     = 1'b0;
        oce_d     = 1'b0;
        ad_d      = ram_ad;
        din_d     = ram_din;
        rsp_vld_d = 1'b0;
        rdata_d   = rsp_rdata;
        err_d     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (misalign) begin
                        rsp_vld_d = 1'b1;
                        err_d     = 1'b1;
                        rdata_d   = 32'h0;
                    end else begin
                        ce_d  = 1'b1;
                        ad_d  = {req_addr[12:2], 1'b0, 2'b00};
                        din_d = req_wdata[15:0];
                        wre_d = req_we & req_wstrb[0];
                    end
                end
            end
            ISSUE_LO: begin
                ce_d  = 1'b1;
                ad_d  = {word_q, 1'b1, 2'b00};
                din_d = wdata_hi_q;
                wre_d = we_q & wstrb_hi_q;
                oce_d = !we_q;
            end
            ISSUE_HI: begin
                if (we_q) begin
                    rsp_vld_d = 1'b1;
                end else begin
                    oce_d = 1'b1;
                end
            end
            READ_HI: begin
                rsp_vld_d = 1'b1;
                rdata_d   = {ram_dout, low_q};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ram_ce    <= 1'b0;
            ram_wre   <= 1'b0;
            ram_oce   <= 1'b0;
            ram_ad    <= 14'h0;
            ram_din   <= 16'h0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
        end else begin
            ram_ce    <= ce_d;
            ram_wre   <= wre_d;
            ram_oce   <= oce_d;
            ram_ad    <= ad_d;
            ram_din   <= din_d;
            rsp_valid <= rsp_vld_d;
            rsp_rdata <= rdata_d;
        end
    end

`ifdef DPB_MEM_CTRL_ALIGN_CHK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_err <= 1'b0;
        end else begin
            rsp_err <= err_d;
        end
    end
`else
    assign rsp_err = 1'b0;
`endif

    // Request context; the low data/strobe half is consumed directly in the accept cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q       <= 1'b0;
            word_q     <= 11'h0;
            wdata_hi_q <= 16'h0;
            wstrb_hi_q <= 1'b0;
            low_q      <= 16'h0;
        end else begin
            if (accept) begin
                we_q       <= req_we;
                word_q     <= req_addr[12:2];
                wdata_hi_q <= req_wdata[31:16];
                wstrb_hi_q <= req_wstrb[1];
            end
            if (state == READ_LO) begin
                low_q <= ram_dout;
            end
        end
    end

endmodule

// File: tb/tb_dpb_mem_ctrl.sv
// Directed bench for dpb_mem_ctrl with a registered-output 16-bit RAM model.
module tb_dpb_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [12:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_wstrb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        ram_reset;
    logic        ram_ce;
    logic        ram_oce;
    logic        ram_wre;
    logic [13:0] ram_ad;
    logic [15:0] ram_din;
    logic [15:0] ram_dout = 16'h0;
    logic [2:0]  ram_blksel;

    dpb_mem_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .ram_reset  (ram_reset),
        .ram_ce     (ram_ce),
        .ram_oce    (ram_oce),
        .ram_wre    (ram_wre),
        .ram_ad     (ram_ad),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout),
        .ram_blksel (ram_blksel)
    );

    always #5 clk = ~clk;

    // RAM model: address/data latched on ce, output register loaded on oce
    logic [15:0] mem [4096];
    logic [15:0] ram_lat = 16'h0;
    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_wre) mem[ram_ad[13:2]] <= ram_din;
            else         ram_lat <= mem[ram_ad[13:2]];
        end
        if (ram_oce) ram_dout <= ram_lat;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Per-transaction observations
    logic [2:1]  s_ce, s_wre, s_oce;
    logic [13:0] s_ad  [1:2];
    logic [15:0] s_din [1:2];
    int          lat;
    logic        got;
    logic        ce_any;
    logic [31:0] r_rdata;
    logic        r_err;

    task automatic xact(input logic we, input logic [12:0] addr, input logic [31:0] wd, input logic [1:0] ws);
        int g;
        g = 0;
        @(negedge clk);
        while (!req_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (!req_ready) chk("ready_timeout", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_wstrb = ws;
        lat = 0; got = 1'b0; ce_any = 1'b0; r_rdata = 32'h0; r_err = 1'b0;
        s_ce = 2'b00; s_wre = 2'b00; s_oce = 2'b00;
        for (int c = 1; c <= 8 && !got; c++) begin
            @(negedge clk);
            if (c == 1) begin
                // Garbage on the request bus while not ready must be ignored
                req_valid = 1'b0;
                req_we    = ~we;
                req_addr  = 13'h1555;
                req_wdata = 32'h5A5A5A5A;
                req_wstrb = ~ws;
            end
            if (c <= 2) begin
                s_ce[c]  = ram_ce;
                s_wre[c] = ram_wre;
                s_oce[c] = ram_oce;
                s_ad[c]  = ram_ad;
                s_din[c] = ram_din;
            end
            if (ram_ce) ce_any = 1'b1;
            if (rsp_valid) begin
                got = 1'b1;
                lat = c;
                r_rdata = rsp_rdata;
                r_err = rsp_err;
            end
        end
        if (!got) chk("rsp_timeout", 32'(got), 32'd1);
    endtask

    typedef struct {
        logic        we;
        logic [12:0] addr;
        logic [31:0] wdata;
        logic [1:0]  wstrb;
        logic [31:0] exp_rdata;
        logic [13:0] exp_ad_lo;
        logic [1:0]  exp_wre;   // {high, low}
    } vec_t;

    vec_t        vecs [14];
    logic [31:0] last_rd;

    int          acc [2];
    int          rsp [2];
    logic [31:0] rd  [2];
    int          na, nr;
    logic        bad;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0;
        vecs[0]  = '{1'b1, 13'h010, 32'hDEADBEEF, 2'b11, 32'h0,        14'h0020, 2'b11};
        vecs[1]  = '{1'b0, 13'h010, 32'h0,        2'b00, 32'hDEADBEEF, 14'h0020, 2'b00};
        vecs[2]  = '{1'b1, 13'h020, 32'h11112222, 2'b11, 32'h0,        14'h0040, 2'b11};
        vecs[3]  = '{1'b1, 13'h020, 32'hAAAABBBB, 2'b10, 32'h0,        14'h0040, 2'b10};
        vecs[4]  = '{1'b0, 13'h020, 32'h0,        2'b00, 32'hAAAA2222, 14'h0040, 2'b00};
        vecs[5]  = '{1'b1, 13'h030, 32'h12345678, 2'b01, 32'h0,        14'h0060, 2'b01};
        vecs[6]  = '{1'b0, 13'h030, 32'h0,        2'b00, 32'h00005678, 14'h0060, 2'b00};
        vecs[7]  = '{1'b1, 13'h040, 32'hFFFFFFFF, 2'b00, 32'h0,        14'h0080, 2'b00};
        vecs[8]  = '{1'b0, 13'h040, 32'h0,        2'b00, 32'h00000000, 14'h0080, 2'b00};
        vecs[9]  = '{1'b1, 13'h1FFC, 32'hCAFEF00D, 2'b11, 32'h0,       14'h3FF8, 2'b11};
        vecs[10] = '{1'b0, 13'h1FFC, 32'h0,       2'b00, 32'hCAFEF00D, 14'h3FF8, 2'b00};
        vecs[11] = '{1'b1, 13'h000, 32'h0BAD0001, 2'b11, 32'h0,        14'h0000, 2'b11};
        vecs[12] = '{1'b1, 13'h004, 32'h0BAD0002, 2'b11, 32'h0,        14'h0008, 2'b11};
        vecs[13] = '{1'b0, 13'h004, 32'h0,        2'b00, 32'h0BAD0002, 14'h0008, 2'b00};

        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_addr = 13'h0; req_wdata = 32'h0; req_wstrb = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err",   32'(rsp_err),   32'd0);
        chk("rst_rsp_rdata", rsp_rdata,      32'h0);
        chk("rst_ram_ce",    32'(ram_ce),    32'd0);
        chk("rst_ram_oce",   32'(ram_oce),   32'd0);
        chk("rst_ram_wre",   32'(ram_wre),   32'd0);
        chk("rst_ram_ad",    32'(ram_ad),    32'h0);
        chk("rst_ram_din",   32'(ram_din),   32'h0);
        chk("rst_ram_reset", 32'(ram_reset), 32'd1);
        chk("blksel",        32'(ram_blksel), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        chk("post_rst_ram_reset", 32'(ram_reset), 32'd0);

        last_rd = 32'h0;
        for (int i = 0; i < 14; i++) begin
            xact(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
            chk($sformatf("v%0d_latency", i), 32'(lat), vecs[i].we ? 32'd3 : 32'd5);
            chk($sformatf("v%0d_err", i),     32'(r_err), 32'd0);
            chk($sformatf("v%0d_ce", i),      32'(s_ce), 32'd3);
            chk($sformatf("v%0d_ad_lo", i),   32'(s_ad[1]), 32'(vecs[i].exp_ad_lo));
            chk($sformatf("v%0d_ad_hi", i),   32'(s_ad[2]), 32'(vecs[i].exp_ad_lo | 14'h4));
            chk($sformatf("v%0d_wre", i),     32'(s_wre), 32'(vecs[i].exp_wre));
            chk($sformatf("v%0d_oce", i),     32'(s_oce), vecs[i].we ? 32'd0 : 32'd2);
            if (vecs[i].we) begin
                chk($sformatf("v%0d_din_lo", i), 32'(s_din[1]), 32'(vecs[i].wdata[15:0]));
                chk($sformatf("v%0d_din_hi", i), 32'(s_din[2]), 32'(vecs[i].wdata[31:16]));
                chk($sformatf("v%0d_rdata_hold", i), r_rdata, last_rd);
            end else begin
                chk($sformatf("v%0d_rdata", i), r_rdata, vecs[i].exp_rdata);
                last_rd = vecs[i].exp_rdata;
            end
            @(negedge clk);
            chk($sformatf("v%0d_pulse", i), 32'(rsp_valid), 32'd0);
            chk($sformatf("v%0d_idle_ce", i), 32'(ram_ce), 32'd0);
        end

        // Back-to-back reads with req_valid held high
        na = 0; nr = 0;
        acc[0] = -1; acc[1] = -1; rsp[0] = -1; rsp[1] = -1;
        rd[0] = 32'h0; rd[1] = 32'h0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 13'h000; req_wdata = 32'h0; req_wstrb = 2'b00;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) @(negedge clk);
            if (na == 1) req_addr = 13'h004;
            if (na >= 2) req_valid = 1'b0;
            if (rsp_valid) begin
                if (nr < 2) begin
                    rsp[nr] = c;
                    rd[nr] = rsp_rdata;
                end
                nr++;
            end
            if (req_valid && req_ready) begin
                if (na < 2) acc[na] = c;
                na++;
            end
        end
        chk("b2b_accepts",   32'(na), 32'd2);
        chk("b2b_responses", 32'(nr), 32'd2);
        chk("b2b_spacing",   32'(acc[1] - acc[0]), 32'd5);
        chk("b2b_lat0",      32'(rsp[0] - acc[0]), 32'd5);
        chk("b2b_lat1",      32'(rsp[1] - acc[1]), 32'd5);
        chk("b2b_rdata0",    rd[0], 32'h0BAD0001);
        chk("b2b_rdata1",    rd[1], 32'h0BAD0002);

        // Reset while in READ_LO aborts the read
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 13'h010;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_read_lo", 32'(ram_oce), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_ram_reset", 32'(ram_reset), 32'd1);
        @(negedge clk);
        chk("abort_ce",  32'(ram_ce),    32'd0);
        chk("abort_oce", 32'(ram_oce),   32'd0);
        chk("abort_wre", 32'(ram_wre),   32'd0);
        chk("abort_rsp", 32'(rsp_valid), 32'd0);
        reset = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid || ram_ce || ram_oce || ram_wre) bad = 1'b1;
        end
        chk("abort_quiet", 32'(bad), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_rdata", rsp_rdata, 32'h0);

        // Misaligned address
        xact(1'b0, 13'h002, 32'h0, 2'b00);
`ifdef DPB_MEM_CTRL_ALIGN_CHK_EN
        chk("align_latency", 32'(lat), 32'd1);
        chk("align_err",     32'(r_err), 32'd1);
        chk("align_rdata",   r_rdata, 32'h0);
        chk("align_no_ce",   32'(ce_any), 32'd0);
        repeat (3) @(negedge clk);
        chk("align_idle_ready", 32'(req_ready), 32'd1);
        chk("align_idle_ce",    32'(ram_ce), 32'd0);
`else
        chk("align_latency", 32'(lat), 32'd5);
        chk("align_err",     32'(r_err), 32'd0);
        chk("align_rdata",   r_rdata, 32'h0BAD0001);
        chk("align_ad_lo",   32'(s_ad[1]), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
